// File: rtl/draw_sequencer.sv
// Sequencer and VGA-bus arbiter for NUM_ENG start/done drawing engines: runs each
// enabled engine once in ascending order (optionally looping) with a per-engine watchdog.
module draw_sequencer #(
   parameter int NUM_ENG = 4,
   parameter int TIMEOUT = 0,
   localparam int IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [NUM_ENG-1:0]     i_en_mask,
   input  logic                   i_loop,
   output logic [NUM_ENG-1:0]     o_eng_start,
   input  logic [NUM_ENG-1:0]     i_eng_done,
   input  logic [8*NUM_ENG-1:0]   i_eng_vga_x,
   input  logic [7*NUM_ENG-1:0]   i_eng_vga_y,
   input  logic [3*NUM_ENG-1:0]   i_eng_vga_colour,
   input  logic [NUM_ENG-1:0]     i_eng_vga_plot,
   output logic [7:0]             o_vga_x,
   output logic [6:0]             o_vga_y,
   output logic [2:0]             o_vga_colour,
   output logic                   o_vga_plot,
   output logic [IDX_W-1:0]       o_active_idx,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [NUM_ENG-1:0]     o_err
);

   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_RELEASE = 2'd2,
      S_FINISH  = 2'd3
   } state_t;

   state_t               r_state;
   logic [NUM_ENG-1:0]   r_mask;
   logic [IDX_W-1:0]     r_active_idx;
   logic [NUM_ENG-1:0]   r_eng_start;
   logic                 r_busy;
   logic                 r_done;
   logic [NUM_ENG-1:0]   r_err;
   logic [WD_W-1:0]      r_wdog;

   state_t               w_state_nxt;
   logic [NUM_ENG-1:0]   w_mask_nxt;
   logic [IDX_W-1:0]     w_idx_nxt;
   logic [NUM_ENG-1:0]   w_start_nxt;
   logic                 w_busy_nxt;
   logic                 w_done_nxt;
   logic [NUM_ENG-1:0]   w_err_nxt;
   logic [WD_W-1:0]      w_wdog_nxt;

   logic [IDX_W:0]       w_low_req;
   logic [IDX_W:0]       w_low_run;
   logic [IDX_W:0]       w_high_run;
   logic                 w_cur_done;
   logic                 w_timeout;
   logic                 w_launch_hi;
   logic                 w_launch_wrap;

   logic [7:0]           w_x_arr   [NUM_ENG];
   logic [6:0]           w_y_arr   [NUM_ENG];
   logic [2:0]           w_col_arr [NUM_ENG];

   // Returns {found, index} of the lowest set mask bit strictly above 'above'.
   function automatic logic [IDX_W:0] f_first_above(input logic [NUM_ENG-1:0] mask,
                                                    input int above);
      logic [IDX_W:0] res;
      res = '0;
      for (int i = NUM_ENG - 1; i >= 0; i--) begin
         if (mask[i] && (i > above)) begin
            res = {1'b1, IDX_W'(i)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   assign w_low_req     = f_first_above(i_en_mask, -1);
   assign w_low_run     = f_first_above(r_mask, -1);
   assign w_high_run    = f_first_above(r_mask, int'(r_active_idx));
   assign w_cur_done    = i_eng_done[r_active_idx];
   assign w_timeout     = (TIMEOUT != 0) && (r_wdog == WD_LAST);
   assign w_launch_hi   = i_start && w_high_run[IDX_W];
   assign w_launch_wrap = i_loop && i_start && w_low_run[IDX_W];

   // State and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_mask       <= '0;
         r_active_idx <= '0;
         r_eng_start  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= '0;
         r_wdog       <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_mask       <= w_mask_nxt;
         r_active_idx <= w_idx_nxt;
         r_eng_start  <= w_start_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_err        <= w_err_nxt;
         r_wdog       <= w_wdog_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = w_low_req[IDX_W] ? S_WAIT : S_FINISH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WAIT: begin
            if (w_cur_done || w_timeout) begin
               w_state_nxt = S_RELEASE;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_RELEASE: begin
            if (w_cur_done) begin
               w_state_nxt = S_RELEASE;
            end else if (w_launch_hi || w_launch_wrap) begin
               w_state_nxt = S_WAIT;
            end else begin
               w_state_nxt = S_FINISH;
            end
         end
         S_FINISH: begin
            if (i_start) begin
               w_state_nxt = S_FINISH;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; launch of an engine and its select share one edge.
   always_comb begin
      w_mask_nxt  = r_mask;
      w_idx_nxt   = r_active_idx;
      w_start_nxt = r_eng_start;
      w_busy_nxt  = r_busy;
      w_done_nxt  = r_done;
      w_err_nxt   = r_err;
      w_wdog_nxt  = r_wdog;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_mask_nxt = i_en_mask;
               w_err_nxt  = '0;
               w_wdog_nxt = '0;
               if (w_low_req[IDX_W]) begin
                  w_idx_nxt   = w_low_req[IDX_W-1:0];
                  w_start_nxt = NUM_ENG'(1) << w_low_req[IDX_W-1:0];
                  w_busy_nxt  = 1'b1;
                  w_done_nxt  = 1'b0;
               end else begin
                  w_busy_nxt = 1'b0;
                  w_done_nxt = 1'b1;
               end
            end else begin
               w_wdog_nxt = '0;
            end
         end
         S_WAIT: begin
            if (w_cur_done) begin
               w_start_nxt = '0;
               w_wdog_nxt  = '0;
            end else if (w_timeout) begin
               w_err_nxt   = r_err | (NUM_ENG'(1) << r_active_idx);
               w_start_nxt = '0;
               w_wdog_nxt  = '0;
            end else begin
               w_wdog_nxt = r_wdog + WD_W'(1);
            end
         end
         S_RELEASE: begin
            if (w_cur_done) begin
               w_wdog_nxt = '0;
            end else if (w_launch_hi) begin
               w_idx_nxt   = w_high_run[IDX_W-1:0];
               w_start_nxt = NUM_ENG'(1) << w_high_run[IDX_W-1:0];
            end else if (w_launch_wrap) begin
               w_idx_nxt   = w_low_run[IDX_W-1:0];
               w_start_nxt = NUM_ENG'(1) << w_low_run[IDX_W-1:0];
            end else begin
               w_busy_nxt = 1'b0;
               w_done_nxt = 1'b1;
            end
         end
         S_FINISH: begin
            if (i_start) begin
               w_done_nxt = 1'b1;
            end else begin
               w_done_nxt = 1'b0;
            end
         end
         default: begin
            w_start_nxt = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
         end
      endcase
   end

   // Slice the packed engine buses so the mux is a plain array select.
   always_comb begin
      for (int i = 0; i < NUM_ENG; i++) begin
         w_x_arr[i]   = i_eng_vga_x[8*i +: 8];
         w_y_arr[i]   = i_eng_vga_y[7*i +: 7];
         w_col_arr[i] = i_eng_vga_colour[3*i +: 3];
      end
   end

   // Pixel bus follows the registered select; plot only passes while the engine is running.
   always_comb begin
      o_vga_x      = w_x_arr[r_active_idx];
      o_vga_y      = w_y_arr[r_active_idx];
      o_vga_colour = w_col_arr[r_active_idx];
      o_vga_plot   = i_eng_vga_plot[r_active_idx] && (r_state == S_WAIT);
   end

   assign o_eng_start  = r_eng_start;
   assign o_active_idx = r_active_idx;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_err        = r_err;

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomized bench for draw_sequencer (3 engines, watchdog 8): engine models plus a
// launch-list reference model predicting every output on every cycle.
module tb_draw_sequencer;

   localparam int N  = 3;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst, start, loop_r;
   logic [2:0]    en_mask, eng_start, eng_done, eng_plot;
   logic [23:0]   eng_x;
   logic [20:0]   eng_y;
   logic [8:0]    eng_col;
   logic [7:0]    vga_x;
   logic [6:0]    vga_y;
   logic [2:0]    vga_col;
   logic          vga_plot, busy, done;
   logic [1:0]    active_idx;
   logic [2:0]    err;

   int            cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;

   int            lat [N];
   bit            hang [N];
   bit            plot_force [N];
   int            cnt [N];
   logic [7:0]    ex [N];
   logic [6:0]    ey [N];
   logic [2:0]    ec [N];
   logic          ep [N];

   int            prev_active;
   logic [2:0]    prev_err;

   draw_sequencer #(.NUM_ENG(N), .TIMEOUT(TO)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_en_mask(en_mask), .i_loop(loop_r),
      .o_eng_start(eng_start), .i_eng_done(eng_done), .i_eng_vga_x(eng_x),
      .i_eng_vga_y(eng_y), .i_eng_vga_colour(eng_col), .i_eng_vga_plot(eng_plot),
      .o_vga_x(vga_x), .o_vga_y(vga_y), .o_vga_colour(vga_col), .o_vga_plot(vga_plot),
      .o_active_idx(active_idx), .o_busy(busy), .o_done(done), .o_err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
      end
   endtask

   // Ideal engines: done rises lat cycles after start is seen, drops once start is low.
   task automatic step_engines();
      for (int i = 0; i < N; i++) begin
         if (eng_start[i]) begin
            cnt[i]++;
            eng_done[i] = !hang[i] && (cnt[i] >= lat[i]);
         end else begin
            cnt[i] = 0;
            eng_done[i] = 1'b0;
         end
         ex[i] = 8'($urandom);
         ey[i] = 7'($urandom);
         ec[i] = 3'($urandom);
         ep[i] = plot_force[i] | 1'($urandom_range(0, 1));
      end
      eng_x    = {ex[2], ex[1], ex[0]};
      eng_y    = {ey[2], ey[1], ey[0]};
      eng_col  = {ec[2], ec[1], ec[0]};
      eng_plot = {ep[2], ep[1], ep[0]};
   endtask

   function automatic int lowest_above(input logic [2:0] m, input int a);
      for (int i = a + 1; i < N; i++) if (m[i]) return i;
      return -1;
   endfunction

   // One run: build the expected launch list, then drive and check cycle by cycle.
   task automatic run_seq(input logic [2:0] mask, input logic lp, input int hold);
      int L_idx[$], L_t[$], L_d[$];
      bit L_to[$];
      int s_e, done_c, fall, clear_c, t, idx, d, dec, nx, fall_m, act;
      bit to, st;
      logic [2:0] exp_start, exp_err;
      @(negedge clk);
      s_e = cyc + 1;
      fall_m = lp ? s_e + hold : 32'h4000_0000;
      if (mask == 3'b000) begin
         done_c = s_e;
      end else begin
         t = s_e;
         idx = lowest_above(mask, -1);
         while (1) begin
            to = hang[idx] || (lat[idx] > TO);
            d  = to ? TO : lat[idx];
            L_idx.push_back(idx); L_t.push_back(t); L_d.push_back(d); L_to.push_back(to);
            dec = t + d + 1;
            st  = dec < fall_m;
            nx  = lowest_above(mask, idx);
            if (st && nx >= 0) begin
               idx = nx; t = dec;
            end else if (lp && st) begin
               idx = lowest_above(mask, -1); t = dec;
            end else begin
               done_c = dec;
               break;
            end
         end
      end
      fall    = lp ? s_e + hold : done_c + 1;
      clear_c = (done_c + 1 > fall) ? done_c + 1 : fall;
      act = prev_active;
      exp_err = prev_err;
      while (cyc <= clear_c + 1) begin
         exp_start = 3'b000;
         act = prev_active;
         exp_err = (cyc >= s_e) ? 3'b000 : prev_err;
         foreach (L_idx[k]) begin
            if (L_t[k] <= cyc) act = L_idx[k];
            if (cyc >= L_t[k] && cyc < L_t[k] + L_d[k]) exp_start[L_idx[k]] = 1'b1;
            if (L_to[k] && cyc >= L_t[k] + L_d[k]) exp_err[L_idx[k]] = 1'b1;
         end
         check_val("eng_start", 32'(eng_start), 32'(exp_start));
         check_val("busy", 32'(busy), 32'(mask != 3'b000 && cyc >= s_e && cyc < done_c));
         check_val("done", 32'(done), 32'(cyc >= done_c && cyc < clear_c));
         check_val("active_idx", 32'(active_idx), 32'(act));
         check_val("err", 32'(err), 32'(exp_err));
         check_val("vga_x", 32'(vga_x), 32'(ex[act]));
         check_val("vga_y", 32'(vga_y), 32'(ey[act]));
         check_val("vga_colour", 32'(vga_col), 32'(ec[act]));
         check_val("vga_plot", 32'(vga_plot), 32'(ep[act] && (exp_start != 3'b000)));
         start   = (cyc + 1 >= s_e) && (cyc + 1 < fall);
         en_mask = (cyc + 1 == s_e) ? mask : 3'($urandom);
         loop_r  = lp;
         step_engines();
         @(negedge clk);
      end
      prev_active = act;
      prev_err    = exp_err;
   endtask

   task automatic set_engines(input int l0, input int l1, input int l2,
                              input bit h0, input bit h1, input bit h2);
      lat[0] = l0; lat[1] = l1; lat[2] = l2;
      hang[0] = h0; hang[1] = h1; hang[2] = h2;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; loop_r = 1'b0; en_mask = 3'b000; eng_done = 3'b000;
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0; plot_force[i] = 1'b0; lat[i] = 5; hang[i] = 1'b0;
      end
      eng_start = 3'b000;
      step_engines();
      repeat (3) @(negedge clk);
      check_val("rst_eng_start", 32'(eng_start), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      check_val("rst_active", 32'(active_idx), 32'd0);
      check_val("rst_plot", 32'(vga_plot), 32'd0);
      rst = 1'b0;
      prev_active = 0;
      prev_err = 3'b000;

      set_engines(5, 5, 5, 0, 0, 0);
      run_seq(3'b011, 1'b0, 0);
      run_seq(3'b000, 1'b0, 0);
      plot_force[2] = 1'b1;
      set_engines(6, 5, 5, 0, 0, 0);
      run_seq(3'b001, 1'b0, 0);
      plot_force[2] = 1'b0;
      set_engines(4, 5, 3, 0, 1, 0);
      run_seq(3'b111, 1'b0, 0);
      set_engines(5, 5, 5, 0, 0, 0);
      run_seq(3'b101, 1'b1, 8);
      set_engines(8, 9, 1, 0, 0, 0);
      run_seq(3'b111, 1'b1, 30);

      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < N; i++) begin
            lat[i]  = $urandom_range(1, 11);
            hang[i] = ($urandom_range(0, 5) == 0);
         end
         plot_force[2] = 1'($urandom_range(0, 1));
         run_seq(3'($urandom), ($urandom_range(0, 2) == 0), $urandom_range(1, 45));
      end
      plot_force[2] = 1'b0;

      // Reset while engine 1 runs, after engine 0 has already timed out.
      set_engines(5, 20, 5, 1, 0, 0);
      @(negedge clk);
      start = 1'b1; en_mask = 3'b011; loop_r = 1'b0;
      step_engines();
      repeat (12) begin
         @(negedge clk);
         step_engines();
      end
      check_val("pre_rst_start", 32'(eng_start), 32'b010);
      check_val("pre_rst_err", 32'(err), 32'b001);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      check_val("mid_rst_start", 32'(eng_start), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_done", 32'(done), 32'd0);
      check_val("mid_rst_err", 32'(err), 32'd0);
      check_val("mid_rst_active", 32'(active_idx), 32'd0);
      check_val("mid_rst_plot", 32'(vga_plot), 32'd0);
      rst = 1'b0;
      step_engines();
      prev_active = 0;
      prev_err = 3'b000;
      set_engines(3, 4, 2, 0, 0, 0);
      run_seq(3'b110, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
